digit_scroller: RTL and testbench

//  Parametrised circular scroller for multi-digit BCD/hex values on a narrower display.

---
 rtl/digit_scroller.sv | 131 +++++++++++++
 tb/tb_digit_scroller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scroller.sv
`default_nettype none
// ============================================================================
// Module      : digit_scroller
// Description : Circular scroller that captures an N_IN-digit value on load
//               and presents a sliding N_OUT-digit window over a ring made of
//               the captured digits followed by GAP blank digits. The window
//               steps left or right every STEP_DIV enabled cycles.
//
// Ports       : clk         - clock, all state on rising edge
//               rst         - synchronous reset, active-high
//               enable      - scroll enable
//               dir         - 0 = scroll left (p+1), 1 = scroll right (p-1)
//               load        - capture in_digits, restart at position 0
//               in_digits   - N_IN digits, most significant in top bits
//               out_digits  - N_OUT-digit window, slot 0 (leftmost) in top bits
//               pos         - current ring position
//               wrap        - one-cycle pulse when the position steps onto 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module digit_scroller #(
    parameter int                 DIGIT_W    = 4,
    parameter int                 N_IN       = 3,
    parameter int                 N_OUT      = 2,
    parameter int                 GAP        = 0,
    parameter int                 STEP_DIV   = 1,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = DIGIT_W'(4'hF),
    localparam int                c_RING_LEN = N_IN + GAP,
    localparam int                c_POS_W    = (c_RING_LEN > 1) ? $clog2(c_RING_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       dir,
    input  logic                       load,
    input  logic [N_IN*DIGIT_W-1:0]    in_digits,
    output logic [N_OUT*DIGIT_W-1:0]   out_digits,
    output logic [c_POS_W-1:0]         pos,
    output logic                       wrap
);

    localparam int                 c_CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEP_DIV - 1);
    localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(c_RING_LEN - 1);

    logic [N_IN*DIGIT_W-1:0]  r_digits;
    logic [c_POS_W-1:0]       r_pos;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_wrap;
    logic [N_OUT*DIGIT_W-1:0] r_out;

    logic                     w_step;
    logic [N_IN*DIGIT_W-1:0]  w_digits_nxt;
    logic [c_POS_W-1:0]       w_pos_nxt;
    logic [c_CNT_W-1:0]       w_cnt_nxt;
    logic                     w_wrap_nxt;
    logic [N_OUT*DIGIT_W-1:0] w_out_nxt;

    // Ring slot lookup: captured digits (most significant first), then blanks.
    function automatic logic [DIGIT_W-1:0] f_ring_digit(
        input logic [N_IN*DIGIT_W-1:0] digits,
        input int                      idx
    );
        logic [DIGIT_W-1:0] d;
        d = BLANK_CODE;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == i) d = digits[(N_IN-1-i)*DIGIT_W +: DIGIT_W];
        end
        return d;
    endfunction

    // Load dominates any step that would otherwise fire on the same edge.
    assign w_step = enable && !load && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_digits_nxt = r_digits;
        w_pos_nxt    = r_pos;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_wrap_nxt   = 1'b0;

        if (load) begin
            w_digits_nxt = in_digits;
            w_pos_nxt    = '0;
            w_cnt_nxt    = '0;
        end else if (!enable) begin
            w_cnt_nxt    = '0;
        end else if (w_step) begin
            w_cnt_nxt = '0;
            if (dir) begin
                w_pos_nxt = (r_pos == '0) ? c_POS_LAST : r_pos - 1'b1;
            end else begin
                w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
            end
            w_wrap_nxt = (w_pos_nxt == '0);
        end
    end

    // Window is built from next-state ring/position so it registers in step
    // with pos. Since pos < L and k < L, one subtraction gives the modulo.
    always_comb begin
        w_out_nxt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            int idx;
            idx = int'(w_pos_nxt) + k;
            if (idx >= c_RING_LEN) idx = idx - c_RING_LEN;
            w_out_nxt[(N_OUT-1-k)*DIGIT_W +: DIGIT_W] = f_ring_digit(w_digits_nxt, idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_pos    <= '0;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
            r_out    <= '0;
        end else begin
            r_digits <= w_digits_nxt;
            r_pos    <= w_pos_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wrap   <= w_wrap_nxt;
            r_out    <= w_out_nxt;
        end
    end

    assign out_digits = r_out;
    assign pos        = r_pos;
    assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_digit_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scroller
// Description : Directed self-checking bench for digit_scroller. Three
//               instances share the stimulus: default parameters, GAP=1, and
//               STEP_DIV=4. Each test checks only the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scroller;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        dir;
    logic        load;
    logic [11:0] in_digits;

    logic [7:0]  out_a, out_g, out_s;
    logic [1:0]  pos_a, pos_g, pos_s;
    logic        wrap_a, wrap_g, wrap_s;

    int errors = 0;
    int checks = 0;

    digit_scroller u_dut_def (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .load(load),
        .in_digits(in_digits), .out_digits(out_a), .pos(pos_a), .wrap(wrap_a)
    );

    digit_scroller #(.GAP(1)) u_dut_gap (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .load(load),
        .in_digits(in_digits), .out_digits(out_g), .pos(pos_g), .wrap(wrap_g)
    );

    digit_scroller #(.STEP_DIV(4)) u_dut_div (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .load(load),
        .in_digits(in_digits), .out_digits(out_s), .pos(pos_s), .wrap(wrap_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_load(input logic [11:0] v);
        rst = 1'b1; load = 1'b0; enable = 1'b0; dir = 1'b0; in_digits = '0;
        tick();
        rst = 1'b0; load = 1'b1; in_digits = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; enable = 1'b0; dir = 1'b0; in_digits = 12'h952;
        tick();
        checks++;
        if (out_a !== 8'h00 || pos_a !== 2'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset: got out=%h pos=%0d wrap=%b expected out=00 pos=0 wrap=0", out_a, pos_a, wrap_a);
        end
    endtask

    task automatic test_scroll_left();
        logic [7:0] eo [3] = '{8'h52, 8'h29, 8'h95};
        logic [1:0] ep [3] = '{2'd1, 2'd2, 2'd0};
        logic       ew [3] = '{1'b0, 1'b0, 1'b1};
        reset_and_load(12'h952);
        checks++;
        if (out_a !== 8'h95 || pos_a !== 2'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL left_load: got out=%h pos=%0d wrap=%b expected out=95 pos=0 wrap=0", out_a, pos_a, wrap_a);
        end
        enable = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_a !== eo[i] || pos_a !== ep[i] || wrap_a !== ew[i]) begin
                errors++;
                $display("FAIL left_step%0d: got out=%h pos=%0d wrap=%b expected out=%h pos=%0d wrap=%b",
                         i, out_a, pos_a, wrap_a, eo[i], ep[i], ew[i]);
            end
        end
        tick();
        checks++;
        if (wrap_a !== 1'b0 || out_a !== 8'h52) begin
            errors++;
            $display("FAIL left_wrap_clear: got out=%h wrap=%b expected out=52 wrap=0", out_a, wrap_a);
        end
    endtask

    task automatic test_scroll_right();
        logic [7:0] eo [5] = '{8'h29, 8'h52, 8'h29, 8'h52, 8'h95};
        logic [1:0] ep [5] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0};
        logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ed [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reset_and_load(12'h952);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dir = ed[i];
            tick();
            checks++;
            if (out_a !== eo[i] || pos_a !== ep[i] || wrap_a !== ew[i]) begin
                errors++;
                $display("FAIL right_step%0d: got out=%h pos=%0d wrap=%b expected out=%h pos=%0d wrap=%b",
                         i, out_a, pos_a, wrap_a, eo[i], ep[i], ew[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0] eo [4] = '{8'h52, 8'h2F, 8'hF9, 8'h95};
        logic [1:0] ep [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        reset_and_load(12'h952);
        checks++;
        if (out_g !== 8'h95 || pos_g !== 2'd0) begin
            errors++;
            $display("FAIL gap_load: got out=%h pos=%0d expected out=95 pos=0", out_g, pos_g);
        end
        enable = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_g !== eo[i] || pos_g !== ep[i] || wrap_g !== ew[i]) begin
                errors++;
                $display("FAIL gap_step%0d: got out=%h pos=%0d wrap=%b expected out=%h pos=%0d wrap=%b",
                         i, out_g, pos_g, wrap_g, eo[i], ep[i], ew[i]);
            end
        end
    endtask

    task automatic test_step_div();
        reset_and_load(12'h952);
        enable = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (out_s !== 8'h95 || pos_s !== 2'd0) begin
            errors++;
            $display("FAIL div_hold3: got out=%h pos=%0d expected out=95 pos=0", out_s, pos_s);
        end
        tick();
        checks++;
        if (out_s !== 8'h52 || pos_s !== 2'd1) begin
            errors++;
            $display("FAIL div_step4: got out=%h pos=%0d expected out=52 pos=1", out_s, pos_s);
        end
        tick(); tick();
        enable = 1'b0;
        tick(); tick();
        checks++;
        if (out_s !== 8'h52 || pos_s !== 2'd1 || wrap_s !== 1'b0) begin
            errors++;
            $display("FAIL div_disabled: got out=%h pos=%0d wrap=%b expected out=52 pos=1 wrap=0", out_s, pos_s, wrap_s);
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pos_s !== 2'd1) begin
            errors++;
            $display("FAIL div_reenable_hold: got pos=%0d expected pos=1", pos_s);
        end
        tick();
        checks++;
        if (out_s !== 8'h29 || pos_s !== 2'd2) begin
            errors++;
            $display("FAIL div_reenable_step: got out=%h pos=%0d expected out=29 pos=2", out_s, pos_s);
        end
    endtask

    task automatic test_load_on_step();
        reset_and_load(12'h952);
        enable = 1'b1; dir = 1'b0;
        tick(); tick();
        checks++;
        if (pos_a !== 2'd2) begin
            errors++;
            $display("FAIL loadstep_pre: got pos=%0d expected pos=2", pos_a);
        end
        load = 1'b1; in_digits = 12'h123;
        tick();
        checks++;
        if (out_a !== 8'h12 || pos_a !== 2'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL loadstep_load: got out=%h pos=%0d wrap=%b expected out=12 pos=0 wrap=0", out_a, pos_a, wrap_a);
        end
        load = 1'b0;
        tick();
        checks++;
        if (out_a !== 8'h23 || pos_a !== 2'd1) begin
            errors++;
            $display("FAIL loadstep_cont: got out=%h pos=%0d expected out=23 pos=1", out_a, pos_a);
        end
        // Input changes without load must not reach the ring.
        in_digits = 12'h777;
        tick();
        checks++;
        if (out_a !== 8'h31 || pos_a !== 2'd2) begin
            errors++;
            $display("FAIL loadstep_noload: got out=%h pos=%0d expected out=31 pos=2", out_a, pos_a);
        end
    endtask

    task automatic test_reset_mid_scroll();
        reset_and_load(12'h952);
        enable = 1'b1; dir = 1'b0;
        tick();
        rst = 1'b1; load = 1'b1; in_digits = 12'h456;
        tick();
        checks++;
        if (out_a !== 8'h00 || pos_a !== 2'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got out=%h pos=%0d wrap=%b expected out=00 pos=0 wrap=0", out_a, pos_a, wrap_a);
        end
        rst = 1'b0; load = 1'b0;
        tick();
        checks++;
        if (out_a !== 8'h00 || pos_a !== 2'd1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got out=%h pos=%0d wrap=%b expected out=00 pos=1 wrap=0", out_a, pos_a, wrap_a);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; dir = 1'b0; load = 1'b0; in_digits = '0;
        #2;
        test_reset();
        test_scroll_left();
        test_scroll_right();
        test_gap();
        test_step_div();
        test_load_on_step();
        test_reset_mid_scroll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
